matrix_c_result_drain: RTL and testbench

//  Downstream stage of matrix_multiplier: captures result matrix C from its write port
//  (en_WriteMat_C/rowAddr_C/colAddr_C/writeData_C) into a ROWSxCOLS register array.

---
 rtl/matrix_c_result_drain.sv | 179 +++++++++++++++++
 tb/tb_matrix_c_result_drain.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_c_result_drain.sv
// Captures result matrix C from the multiplier's write port, then streams it out row-major
// over valid/ready. Define RESULT_CHECKSUM_EN to add the out_checksum running-sum output.
module matrix_c_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 10,
    parameter int COLS       = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_WriteMat_C,
    input  logic [ADDR_WIDTH-1:0] rowAddr_C,
    input  logic [ADDR_WIDTH-1:0] colAddr_C,
    input  logic [DATA_WIDTH-1:0] writeData_C,
    input  logic                  resultIsInvalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_row,
    output logic [ADDR_WIDTH-1:0] out_col,
    output logic                  out_last,
    output logic                  out_invalid,
    output logic [6:0]            fill_count,
`ifdef RESULT_CHECKSUM_EN
    output logic [DATA_WIDTH+7:0] out_checksum,
`endif
    output logic                  wr_overrun,
    output logic                  addr_err
);

    typedef enum logic {S_FILL, S_DRAIN} state_e;

    localparam logic [ADDR_WIDTH-1:0] ROW_MAX = ADDR_WIDTH'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(COLS - 1);
    localparam logic [6:0]            FULL    = 7'(ROWS * COLS);

    state_e                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  written_q, written_d;
    logic [6:0]                 fill_q, fill_d;
    logic                       inv_acc_q, inv_acc_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_invalid_q, out_invalid_d;
    logic                       wr_overrun_q, wr_overrun_d;
    logic                       addr_err_q, addr_err_d;
    logic [ADDR_WIDTH-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0]      col_q, col_d;
    logic [DATA_WIDTH-1:0]      mem_q [ROWS][COLS];
    logic                       mem_we;
    logic                       in_range;
    logic                       xfer;
    logic                       last;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_WIDTH+7:0]      sum_q, sum_d;
`endif

    assign in_range = (rowAddr_C <= ROW_MAX) && (colAddr_C <= COL_MAX);
    assign xfer     = out_valid_q && out_ready;
    assign last     = out_valid_q && (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        written_d     = written_q;
        fill_d        = fill_q;
        inv_acc_d     = inv_acc_q;
        out_valid_d   = out_valid_q;
        out_invalid_d = out_invalid_q;
        wr_overrun_d  = wr_overrun_q;
        addr_err_d    = addr_err_q;
        row_d         = row_q;
        col_d         = col_q;
        mem_we        = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            S_FILL: begin
                if (resultIsInvalid) inv_acc_d = 1'b1;
                if (en_WriteMat_C) begin
                    if (in_range) begin
                        mem_we = 1'b1;
                        if (!written_q[rowAddr_C][colAddr_C]) begin
                            written_d[rowAddr_C][colAddr_C] = 1'b1;
                            fill_d = fill_q + 7'd1;
                        end
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // Drain starts the edge after the count reaches full, not the same edge.
                if (fill_q == FULL) begin
                    state_d       = S_DRAIN;
                    out_valid_d   = 1'b1;
                    row_d         = '0;
                    col_d         = '0;
                    out_invalid_d = inv_acc_q;
                end
            end
            S_DRAIN: begin
                if (en_WriteMat_C) wr_overrun_d = 1'b1;
                if (xfer) begin
`ifdef RESULT_CHECKSUM_EN
                    sum_d = sum_q + {8'd0, out_data};
`endif
                    if (last) begin
                        state_d       = S_FILL;
                        out_valid_d   = 1'b0;
                        written_d     = '0;
                        fill_d        = '0;
                        inv_acc_d     = 1'b0;
                        out_invalid_d = 1'b0;
                        row_d         = '0;
                        col_d         = '0;
`ifdef RESULT_CHECKSUM_EN
                        sum_d         = '0;
`endif
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + ADDR_WIDTH'(1);
                    end else begin
                        col_d = col_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_FILL;
            written_q     <= '0;
            fill_q        <= '0;
            inv_acc_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_invalid_q <= 1'b0;
            wr_overrun_q  <= 1'b0;
            addr_err_q    <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
`ifdef RESULT_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            written_q     <= written_d;
            fill_q        <= fill_d;
            inv_acc_q     <= inv_acc_d;
            out_valid_q   <= out_valid_d;
            out_invalid_q <= out_invalid_d;
            wr_overrun_q  <= wr_overrun_d;
            addr_err_q    <= addr_err_d;
            row_q         <= row_d;
            col_q         <= col_d;
`ifdef RESULT_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // NOTE: the element array is deliberately not reset; the written bitmap says what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[rowAddr_C][colAddr_C] <= writeData_C;
    end

    assign out_valid   = out_valid_q;
    assign out_data    = mem_q[row_q][col_q];
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign out_last    = last;
    assign out_invalid = out_invalid_q;
    assign fill_count  = fill_q;
    assign wr_overrun  = wr_overrun_q;
    assign addr_err    = addr_err_q;
`ifdef RESULT_CHECKSUM_EN
    assign out_checksum = sum_q + (last ? {8'd0, out_data} : '0);
`endif

endmodule

// File: tb/tb_matrix_c_result_drain.sv
// Self-checking bench for matrix_c_result_drain: a beat-indexed reference model checked every
// negedge, plus directed fill/drain scenarios with hand-computed literal expectations.
module tb_matrix_c_result_drain;

    localparam int DW   = 8;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int AW   = 4;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] wr_row = '0;
    logic [AW-1:0] wr_col = '0;
    logic [DW-1:0] wr_data = '0;
    logic          res_inv = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid, out_last, out_invalid, wr_overrun, addr_err;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_row, out_col;
    logic [6:0]    fill_count;
`ifdef RESULT_CHECKSUM_EN
    logic [DW+7:0] out_checksum;
    logic [DW+7:0] last_ck;
`endif

    matrix_c_result_drain dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .en_WriteMat_C   (en),
        .rowAddr_C       (wr_row),
        .colAddr_C       (wr_col),
        .writeData_C     (wr_data),
        .resultIsInvalid (res_inv),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row         (out_row),
        .out_col         (out_col),
        .out_last        (out_last),
        .out_invalid     (out_invalid),
        .fill_count      (fill_count),
`ifdef RESULT_CHECKSUM_EN
        .out_checksum    (out_checksum),
`endif
        .wr_overrun      (wr_overrun),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one linear beat index over a flat copy of C.
    bit            m_fill;
    int            m_cnt;
    bit            m_set [N];
    logic [DW-1:0] m_mem [N];
    bit            m_inv, m_out_inv, m_valid, m_over, m_aerr;
    int            m_beat;
    int            m_sum;

    always @(posedge clk or negedge reset_n) begin
        bit full;
        int idx;
        if (!reset_n) begin
            m_fill = 1'b1; m_cnt = 0; m_inv = 0; m_out_inv = 0; m_valid = 0;
            m_over = 0; m_aerr = 0; m_beat = 0; m_sum = 0;
            foreach (m_set[i]) m_set[i] = 1'b0;
        end else if (m_fill) begin
            full = (m_cnt == N);
            if (res_inv) m_inv = 1'b1;
            if (en) begin
                if (int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
                    idx = int'(wr_row) * COLS + int'(wr_col);
                    m_mem[idx] = wr_data;
                    if (!m_set[idx]) begin
                        m_set[idx] = 1'b1;
                        m_cnt++;
                    end
                end else begin
                    m_aerr = 1'b1;
                end
            end
            if (full) begin
                m_fill = 1'b0; m_valid = 1'b1; m_beat = 0; m_out_inv = m_inv; m_sum = 0;
            end
        end else begin
            if (en) m_over = 1'b1;
            if (out_ready) begin
                m_sum = (m_sum + int'(m_mem[m_beat])) % 65536;
                if (m_beat == N - 1) begin
                    m_fill = 1'b1; m_valid = 0; m_cnt = 0; m_inv = 0; m_out_inv = 0;
                    m_beat = 0; m_sum = 0;
                    foreach (m_set[i]) m_set[i] = 1'b0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // Compare process plus observed-beat log.
    logic [DW-1:0] obs[$];
    int            last_idx;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_row, prev_col;

    always @(negedge clk) begin
        if (reset_n) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("fill_count", 32'(fill_count), 32'(m_cnt));
            check("wr_overrun", 32'(wr_overrun), 32'(m_over));
            check("addr_err", 32'(addr_err), 32'(m_aerr));
            check("out_invalid", 32'(out_invalid), 32'(m_out_inv));
            check("out_last", 32'(out_last), 32'(m_valid && m_beat == N - 1));
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(m_mem[m_beat]));
                check("out_row", 32'(out_row), 32'(m_beat / COLS));
                check("out_col", 32'(out_col), 32'(m_beat % COLS));
`ifdef RESULT_CHECKSUM_EN
                if (m_beat == N - 1) begin
                    check("out_checksum", 32'(out_checksum),
                          32'((m_sum + int'(m_mem[N-1])) % 65536));
                    last_ck = out_checksum;
                end
`endif
            end
            if (prev_stall) begin
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_row", 32'(out_row), 32'(prev_row));
                check("hold_col", 32'(out_col), 32'(prev_col));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_row   = out_row;
            prev_col   = out_col;
            if (out_valid && out_ready) begin
                obs.push_back(out_data);
                if (out_last) last_idx = obs.size() - 1;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [DW-1:0] gen(input int mode, input int k);
        case (mode)
            0:       return DW'(k);
            1:       return DW'(k) ^ 8'hA5;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic do_write(input int r, input int c, input logic [DW-1:0] d);
        en      = 1'b1;
        wr_row  = AW'(r);
        wr_col  = AW'(c);
        wr_data = d;
        @(posedge clk); #2;
        en = 1'b0;
    endtask

    task automatic fill(input int mode, input bit rev);
        for (int n = 0; n < N; n++) begin
            int k;
            k = rev ? N - 1 - n : n;
            do_write(k / COLS, k % COLS, gen(mode, k));
        end
    endtask

    task automatic start_stream();
        obs.delete();
        last_idx = -1;
    endtask

    task automatic wait_stream(input string name, input bit toggle);
        int n;
        n = 0;
        while (obs.size() < N && n < 2000) begin
            if (toggle) out_ready = (n % 4 == 0) || (n % 4 == 3);
            @(posedge clk); #2;
            n++;
        end
        out_ready = 1'b1;
        check({name, "_beats"}, 32'(obs.size()), 32'(N));
        check({name, "_last_idx"}, 32'(last_idx), 32'(N - 1));
    endtask

    task automatic check_seq(input string name, input int mode);
        for (int k = 0; k < N && k < obs.size(); k++)
            check(name, 32'(obs[k]), 32'(gen(mode, k)));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_invalid", 32'(out_invalid), 32'd0);
        check("rst_overrun", 32'(wr_overrun), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);

        // 1: row-major fill, full-rate drain.
        out_ready = 1'b1;
        start_stream();
        fill(0, 1'b0);
        check("t1_full", 32'(fill_count), 32'd100);
        check("t1_valid_pre", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        check("t1_valid_start", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(out_data), 32'd0);
        wait_stream("t1", 1'b0);
        check_seq("t1_seq", 0);
        check("t1_beat99", 32'(obs[99]), 32'd99);
        check("t1_fill_after", 32'(fill_count), 32'd0);
        check("t1_valid_after", 32'(out_valid), 32'd0);

        // 2: reverse fill, stream still row-major.
        start_stream();
        fill(1, 1'b1);
        check("t2_full", 32'(fill_count), 32'd100);
        wait_stream("t2", 1'b0);
        check_seq("t2_seq", 1);
        check("t2_beat0", 32'(obs[0]), 32'hA5);

        // 3: rewrite of one element.
        start_stream();
        do_write(3, 4, 8'd7);
        do_write(3, 4, 8'd55);
        check("t3_rewrite_cnt", 32'(fill_count), 32'd1);
        for (int k = 0; k < N; k++)
            if (k != 34) do_write(k / COLS, k % COLS, gen(0, k));
        check("t3_full", 32'(fill_count), 32'd100);
        wait_stream("t3", 1'b0);
        check("t3_beat34", 32'(obs[34]), 32'd55);
        check("t3_beat35", 32'(obs[35]), 32'd35);

        // 4: back-pressure pattern 1-0-0-1.
        start_stream();
        fill(0, 1'b0);
        wait_stream("t4", 1'b1);
        check_seq("t4_seq", 0);

        // 5: out-of-range writes in FILL, overrun write in DRAIN.
        start_stream();
        do_write(10, 0, 8'd1);
        do_write(0, 12, 8'd2);
        check("t5_addr_err", 32'(addr_err), 32'd1);
        check("t5_fill_unch", 32'(fill_count), 32'd0);
        out_ready = 1'b0;
        fill(0, 1'b0);
        @(posedge clk); #2;
        check("t5_overrun_pre", 32'(wr_overrun), 32'd0);
        do_write(0, 0, 8'hEE);
        check("t5_overrun", 32'(wr_overrun), 32'd1);
        out_ready = 1'b1;
        wait_stream("t5", 1'b0);
        check_seq("t5_seq", 0);
        check("t5_beat0", 32'(obs[0]), 32'd0);

        // 6: invalid flag, then reset mid-drain.
        start_stream();
        res_inv = 1'b1;
        @(posedge clk); #2;
        res_inv = 1'b0;
        fill(1, 1'b0);
        @(posedge clk); #2;
        check("t6_invalid_on", 32'(out_invalid), 32'd1);
        wait_stream("t6a", 1'b0);
        check("t6_invalid_clr", 32'(out_invalid), 32'd0);
        start_stream();
        fill(0, 1'b0);
        @(posedge clk); #2;
        check("t6_invalid_next", 32'(out_invalid), 32'd0);
        begin
            int n;
            n = 0;
            while (obs.size() < 40 && n < 500) begin
                @(posedge clk); #2;
                n++;
            end
        end
        check("t6_beat40_reached", 32'(obs.size()), 32'd40);
        check("t6_presenting", 32'(out_data), 32'd40);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_fill", 32'(fill_count), 32'd0);
        check("t6_rst_overrun", 32'(wr_overrun), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        check("t6_post_valid", 32'(out_valid), 32'd0);
        do_write(5, 5, 8'd9);
        check("t6_post_fill", 32'(fill_count), 32'd1);

`ifdef RESULT_CHECKSUM_EN
        start_stream();
        fill(2, 1'b0);
        wait_stream("ck", 1'b0);
        check_seq("ck_seq", 2);
        check("ck_literal", 32'(last_ck), 32'h639C);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
